// File: rtl/rsa_ser_pkg.sv
// rsa_ser_pkg: shared constants and state encoding for the
// RSA result serializer (word width, header magic, FSM states).
package rsa_ser_pkg;

   localparam int WORD_W = 32;

   localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_HDR  = 2'd1;
   localparam state_t S_SEND = 2'd2;

   // Word index width; a one-word block still needs a 1-bit index.
   function automatic int idx_width(input int nwords);
      return (nwords > 1) ? $clog2(nwords) : 1;
   endfunction

endpackage

// File: rtl/rsa_result_serializer.sv
// rsa_result_serializer: splits one wide RSA result block into
// 32-bit words, least-significant first, into an output FIFO.
// Ports:
//   hclk, hresetn         clock, async active-low reset
//   flush                 sync abort of the block in progress
//   in_data/in_valid/in_ready   block handshake from the RSA core
//   out_data/out_wen      FIFO write port, fifo_full backpressure
//   busy                  a block is being emitted
//   blocks_done           wrapping count of fully emitted blocks
// Build option: RSA_SER_HDR_EN adds a header word
//   {HDR_MAGIC, 8'h00, NWORDS} ahead of every block.
module rsa_result_serializer
   import rsa_ser_pkg::*;
#(
   parameter int IN_W  = 256,
   parameter int CNT_W = 16
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic             flush,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      out_data,
   output logic             out_wen,
   input  logic             fifo_full,
   output logic             busy,
   output logic [CNT_W-1:0] blocks_done
);

   localparam int NWORDS = IN_W / WORD_W;
   localparam int IDX_W  = idx_width(NWORDS);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

`ifdef RSA_SER_HDR_EN
   localparam logic [31:0] HDR_WORD = {HDR_MAGIC, 8'h00, 8'(NWORDS)};
   localparam state_t      FIRST_ST = S_HDR;
`else
   localparam state_t      FIRST_ST = S_SEND;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [IN_W-1:0]  shreg;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] done_cnt;

   logic capture;
   logic pay_wr;
   logic last_wr;

   assign capture = (state == S_IDLE) & in_valid & ~flush;
   assign pay_wr  = (state == S_SEND) & out_wen;
   assign last_wr = pay_wr & (idx == LAST_IDX);

   assign blocks_done = done_cnt;

   // State register
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; flush wins over everything else
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  state_nxt = FIRST_ST;
               end
            end
`ifdef RSA_SER_HDR_EN
            S_HDR: begin
               if (out_wen) begin
                  state_nxt = S_SEND;
               end
            end
`endif
            S_SEND: begin
               if (last_wr) begin
                  state_nxt = S_IDLE;
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Output logic; writes are gated by the FIFO full flag and flush
   always_comb begin
      in_ready = (state == S_IDLE);
      busy     = (state != S_IDLE);
      out_wen  = 1'b0;
      out_data = shreg[WORD_W-1:0];
      unique case (state)
`ifdef RSA_SER_HDR_EN
         S_HDR: begin
            out_wen  = ~fifo_full & ~flush;
            out_data = HDR_WORD;
         end
`endif
         S_SEND: begin
            out_wen = ~fifo_full & ~flush;
         end
         default: begin
            out_wen = 1'b0;
         end
      endcase
   end

   // Shift register and word index; both hold while the FIFO is full
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         shreg <= '0;
         idx   <= '0;
      end else if (flush) begin
         shreg <= '0;
         idx   <= '0;
      end else if (capture) begin
         shreg <= in_data;
         idx   <= '0;
      end else if (pay_wr) begin
         shreg <= shreg >> WORD_W;
         idx   <= idx + 1'b1;
      end
   end

   // Completed-block counter, wraps naturally
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         done_cnt <= '0;
      end else if (last_wr) begin
         done_cnt <= done_cnt + 1'b1;
      end
   end

endmodule
